exec_seq: RTL and testbench

Run sequencer for the compute core between `src_buf` and `dst_buf`. On a start pulse it walks an `out_n × in_n` tap nest and drives the `src_buf` read strobe and address (`exec`, `ia`) plus a weight-buffer address. It aligns accumulate/clear markers to the one-cycle `src_buf` read latency. After the core pipeline delay it issues the `dst_buf` write request (`outr`, `oa`), timed so that the core result `x` is valid the cycle after `outr`.

---
 rtl/exec_seq_pkg.sv | 19 +
 rtl/exec_seq_if.sv | 41 ++++
 rtl/exec_seq_tag_delay.sv | 38 +++
 rtl/exec_seq.sv | 132 +++++++++++++
 tb/tb_exec_seq.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_seq_pkg.sv
// Shared types for the exec_seq run sequencer.
// FSM states, default address width and the tap tag.
package exec_pkg;

  localparam int AW_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } exec_st_t;

  typedef struct packed {
    logic              first;
    logic              last;
    logic [AW_DEF-1:0] oa;
  } tag_t;

endpackage

// File: rtl/exec_seq_if.sv
// Control, src/weight issue and dst write bundle
// between the host/core and the exec_seq sequencer.
interface exec_seq_if #(
  parameter int AW = exec_pkg::AW_DEF
) ();

  logic          start;
  logic [AW-1:0] in_n;
  logic [AW-1:0] out_n;
  logic [AW-1:0] in_base;
  logic [AW-1:0] w_base;
  logic [AW-1:0] o_base;
  logic          src_v;

  logic          busy;
  logic          done;
  logic          exec;
  logic [AW-1:0] ia;
  logic [AW-1:0] wa;
  logic          acc_v;
  logic          init;
  logic          outr;
  logic [AW-1:0] oa;

  modport master (
    output start, in_n, out_n,
    output in_base, w_base, o_base,
    output src_v,
    input  busy, done, exec, ia, wa,
    input  acc_v, init, outr, oa
  );

  modport slave (
    input  start, in_n, out_n,
    input  in_base, w_base, o_base,
    input  src_v,
    output busy, done, exec, ia, wa,
    output acc_v, init, outr, oa
  );

endinterface

// File: rtl/exec_seq_tag_delay.sv
// Fixed-depth shift register of a tag plus valid bit.
// Shifts every cycle; any_v reports an occupied slot.
module tag_delay #(
  parameter int  DEPTH = 1,
  parameter type T     = exec_pkg::tag_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_v,
  input  T     in_d,
  output logic out_v,
  output T     out_d,
  output logic any_v
);

  logic [DEPTH-1:0] v;
  T                 d [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++)
        d[i] <= '0;
    end else begin
      v[0] <= in_v;
      d[0] <= in_d;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end

  assign out_v = v[DEPTH-1];
  assign out_d = d[DEPTH-1];
  assign any_v = |v;

endmodule

// File: rtl/exec_seq.sv
// Run sequencer: walks the out_n x in_n tap nest,
// issues src/weight reads and times dst_buf writes.
module exec_seq #(
  parameter int CORE_LAT = 2,
  parameter int AW       = exec_pkg::AW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  exec_seq_if.slave  bus
);
  import exec_pkg::*;

  typedef struct packed {
    logic          first;
    logic          last;
    logic [AW-1:0] oa;
  } tagw_t;

  localparam logic [AW-1:0] ONE = 1;

  exec_st_t      st, nxt;
  logic [AW-1:0] k, o, w_ofs;
  logic [AW-1:0] n_in, n_out;
  logic [AW-1:0] b_in, b_w, b_o;

  logic  issue, k_end, run_end, empty_req;
  logic  a_v, a_any, l_v, l_any, pipe_any;
  logic  outr_i;
  tagw_t tag, a_d, l_d;
  logic  unused_tag;

  assign empty_req = (bus.in_n == '0) ||
                     (bus.out_n == '0);
  assign issue     = (st == RUN) && !bus.src_v;
  assign k_end     = (k == n_in - ONE);
  assign run_end   = k_end && (o == n_out - ONE);
  assign pipe_any  = a_any | l_any;

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE: if (bus.start)
              nxt = empty_req ? DRAIN : RUN;
      RUN:  if (issue && run_end)
              nxt = DRAIN;
      DRAIN: if (!pipe_any)
              nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      o     <= '0;
      w_ofs <= '0;
      n_in  <= '0;
      n_out <= '0;
      b_in  <= '0;
      b_w   <= '0;
      b_o   <= '0;
    end else if (st == IDLE && bus.start) begin
      k     <= '0;
      o     <= '0;
      w_ofs <= '0;
      n_in  <= bus.in_n;
      n_out <= bus.out_n;
      b_in  <= bus.in_base;
      b_w   <= bus.w_base;
      b_o   <= bus.o_base;
    end else if (issue) begin
      // weight offset runs linearly across the whole nest
      w_ofs <= w_ofs + ONE;
      if (k_end) begin
        k <= '0;
        o <= o + ONE;
      end else begin
        k <= k + ONE;
      end
    end
  end

  assign tag.first = (k == '0);
  assign tag.last  = k_end;
  assign tag.oa    = b_o + o;

  tag_delay #(
    .DEPTH (1),
    .T     (tagw_t)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .in_v  (issue),
    .in_d  (tag),
    .out_v (a_v),
    .out_d (a_d),
    .any_v (a_any)
  );

  tag_delay #(
    .DEPTH (CORE_LAT),
    .T     (tagw_t)
  ) u_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .in_v  (issue),
    .in_d  (tag),
    .out_v (l_v),
    .out_d (l_d),
    .any_v (l_any)
  );

  assign unused_tag = &{1'b0, a_d.last,
                        a_d.oa, l_d.first};

  assign outr_i    = l_v & l_d.last;
  assign bus.busy  = (st != IDLE);
  assign bus.done  = (st == DRAIN) && !pipe_any;
  assign bus.exec  = issue;
  assign bus.ia    = issue ? b_in + k : '0;
  assign bus.wa    = issue ? b_w + w_ofs : '0;
  assign bus.acc_v = a_v;
  assign bus.init  = a_v & a_d.first;
  assign bus.outr  = outr_i;
  assign bus.oa    = outr_i ? l_d.oa : '0;

endmodule

// File: tb/tb_exec_seq.sv
// Directed bench for exec_seq: per-cycle event masks
// compared with hand-computed expected timelines.
module tb_exec_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  exec_seq_if #(.AW(12)) bus ();

  exec_seq #(
    .CORE_LAT (2),
    .AW       (12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [31:0]  m_exec, m_acc, m_init;
  logic [31:0]  m_outr, m_done, m_busy;
  logic [127:0] ia_cat, wa_cat, oa_cat;

  task automatic capture(input int c);
    m_exec[c] = bus.exec;
    m_acc[c]  = bus.acc_v;
    m_init[c] = bus.init;
    m_outr[c] = bus.outr;
    m_done[c] = bus.done;
    m_busy[c] = bus.busy;
    if (bus.exec === 1'b1) begin
      ia_cat = {ia_cat[115:0], bus.ia};
      wa_cat = {wa_cat[115:0], bus.wa};
    end
    if (bus.outr === 1'b1)
      oa_cat = {oa_cat[115:0], bus.oa};
  endtask

  // start at cycle 0, then record cycles 1..ncyc
  task automatic run(input int ni, input int no,
                     input int ib, input int wb,
                     input int ob, input int slo,
                     input int shi, input int rs,
                     input int ncyc);
    m_exec = '0; m_acc = '0; m_init = '0;
    m_outr = '0; m_done = '0; m_busy = '0;
    ia_cat = '0; wa_cat = '0; oa_cat = '0;
    @(posedge clk); #1;
    bus.in_n    = ni[11:0];
    bus.out_n   = no[11:0];
    bus.in_base = ib[11:0];
    bus.w_base  = wb[11:0];
    bus.o_base  = ob[11:0];
    bus.src_v   = 1'b0;
    bus.start   = 1'b1;
    #1 capture(0);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.in_n    = 12'd9;
    bus.out_n   = 12'd9;
    bus.in_base = 12'd100;
    bus.w_base  = 12'd200;
    bus.o_base  = 12'd300;
    for (int c = 1; c <= ncyc; c++) begin
      bus.src_v = (c >= slo && c <= shi);
      bus.start = (c == rs);
      #1 capture(c);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.src_v = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 0; bus.src_v = 0;
    bus.in_n = 0; bus.out_n = 0;
    bus.in_base = 0; bus.w_base = 0; bus.o_base = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.exec, bus.acc_v,
         bus.init, bus.outr} !== 6'b0) begin
      errs++;
      $display("FAIL reset_ctl got %b want 000000",
        {bus.busy, bus.done, bus.exec, bus.acc_v,
         bus.init, bus.outr});
    end
    checks++;
    if ({bus.ia, bus.wa, bus.oa} !== 36'd0) begin
      errs++;
      $display("FAIL reset_addr got %h want 0",
        {bus.ia, bus.wa, bus.oa});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    run(3, 2, 0, 0, 0, 0, -1, 3, 14);
    checks++;
    if (m_exec !== 32'h7E) begin errs++;
      $display("FAIL basic_exec got %h want 7e", m_exec); end
    checks++;
    if (m_acc !== 32'hFC) begin errs++;
      $display("FAIL basic_acc got %h want fc", m_acc); end
    checks++;
    if (m_init !== 32'h24) begin errs++;
      $display("FAIL basic_init got %h want 24", m_init); end
    checks++;
    if (m_outr !== 32'h120) begin errs++;
      $display("FAIL basic_outr got %h want 120", m_outr); end
    checks++;
    if (m_done !== 32'h200) begin errs++;
      $display("FAIL basic_done got %h want 200", m_done); end
    checks++;
    if (m_busy !== 32'h3FE) begin errs++;
      $display("FAIL basic_busy got %h want 3fe", m_busy); end
    checks++;
    if (ia_cat !== 128'({12'd0, 12'd1, 12'd2,
                         12'd0, 12'd1, 12'd2})) begin
      errs++;
      $display("FAIL basic_ia got %h", ia_cat); end
    checks++;
    if (wa_cat !== 128'({12'd0, 12'd1, 12'd2,
                         12'd3, 12'd4, 12'd5})) begin
      errs++;
      $display("FAIL basic_wa got %h", wa_cat); end
    checks++;
    if (oa_cat !== 128'({12'd0, 12'd1})) begin errs++;
      $display("FAIL basic_oa got %h want 000001", oa_cat); end
  endtask

  task automatic test_back_to_back;
    run(1, 4, 7, 0, 10, 0, -1, -1, 12);
    checks++;
    if (m_exec !== 32'h1E) begin errs++;
      $display("FAIL b2b_exec got %h want 1e", m_exec); end
    checks++;
    if (m_init !== 32'h3C) begin errs++;
      $display("FAIL b2b_init got %h want 3c", m_init); end
    checks++;
    if (m_outr !== 32'h78) begin errs++;
      $display("FAIL b2b_outr got %h want 78", m_outr); end
    checks++;
    if (m_done !== 32'h80) begin errs++;
      $display("FAIL b2b_done got %h want 80", m_done); end
    checks++;
    if (oa_cat !== 128'({12'd10, 12'd11,
                         12'd12, 12'd13})) begin
      errs++;
      $display("FAIL b2b_oa got %h", oa_cat); end
    checks++;
    if (ia_cat !== 128'({12'd7, 12'd7,
                         12'd7, 12'd7})) begin
      errs++;
      $display("FAIL b2b_ia got %h", ia_cat); end
  endtask

  task automatic test_stall;
    run(3, 2, 0, 0, 0, 3, 4, -1, 16);
    checks++;
    if (m_exec !== 32'h1E6) begin errs++;
      $display("FAIL stall_exec got %h want 1e6", m_exec); end
    checks++;
    if (m_acc !== 32'h3CC) begin errs++;
      $display("FAIL stall_acc got %h want 3cc", m_acc); end
    checks++;
    if (m_init !== 32'h84) begin errs++;
      $display("FAIL stall_init got %h want 84", m_init); end
    checks++;
    if (m_outr !== 32'h480) begin errs++;
      $display("FAIL stall_outr got %h want 480", m_outr); end
    checks++;
    if (m_done !== 32'h800) begin errs++;
      $display("FAIL stall_done got %h want 800", m_done); end
    checks++;
    if (ia_cat !== 128'({12'd0, 12'd1, 12'd2,
                         12'd0, 12'd1, 12'd2})) begin
      errs++;
      $display("FAIL stall_ia got %h", ia_cat); end
  endtask

  task automatic test_wrap;
    run(4, 1, 4094, 4095, 4095, 0, -1, -1, 12);
    checks++;
    if (ia_cat !== 128'({12'd4094, 12'd4095,
                         12'd0, 12'd1})) begin
      errs++;
      $display("FAIL wrap_ia got %h", ia_cat); end
    checks++;
    if (wa_cat !== 128'({12'd4095, 12'd0,
                         12'd1, 12'd2})) begin
      errs++;
      $display("FAIL wrap_wa got %h", wa_cat); end
    checks++;
    if (m_outr !== 32'h40) begin errs++;
      $display("FAIL wrap_outr got %h want 40", m_outr); end
    checks++;
    if (oa_cat !== 128'(12'd4095)) begin errs++;
      $display("FAIL wrap_oa got %h want fff", oa_cat); end
    checks++;
    if (m_done !== 32'h80) begin errs++;
      $display("FAIL wrap_done got %h want 80", m_done); end
  endtask

  task automatic test_empty;
    run(0, 5, 0, 0, 0, 0, -1, 1, 6);
    checks++;
    if (m_exec !== 32'h0) begin errs++;
      $display("FAIL empty_exec got %h want 0", m_exec); end
    checks++;
    if (m_outr !== 32'h0) begin errs++;
      $display("FAIL empty_outr got %h want 0", m_outr); end
    checks++;
    if (m_done !== 32'h2) begin errs++;
      $display("FAIL empty_done got %h want 2", m_done); end
    checks++;
    if (m_busy !== 32'h2) begin errs++;
      $display("FAIL empty_busy got %h want 2", m_busy); end
  endtask

  task automatic test_reset_mid;
    int cnt;
    @(posedge clk); #1;
    bus.in_n = 12'd3; bus.out_n = 12'd2;
    bus.in_base = 12'd5; bus.w_base = 12'd0;
    bus.o_base = 12'd0; bus.src_v = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.exec !== 1'b1 || bus.ia !== 12'd5) begin
      errs++;
      $display("FAIL rmid_pre exec=%b ia=%0d want 1 5",
        bus.exec, bus.ia); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.exec, bus.acc_v,
         bus.init, bus.outr} !== 6'b0) begin
      errs++;
      $display("FAIL rmid_ctl got %b want 000000",
        {bus.busy, bus.done, bus.exec, bus.acc_v,
         bus.init, bus.outr});
    end
    checks++;
    if ({bus.ia, bus.wa, bus.oa} !== 36'd0) begin
      errs++;
      $display("FAIL rmid_addr got %h want 0",
        {bus.ia, bus.wa, bus.oa});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      cnt += int'(bus.outr) + int'(bus.exec) +
             int'(bus.done);
    end
    checks++;
    if (cnt !== 0) begin errs++;
      $display("FAIL rmid_quiet got %0d events want 0",
        cnt); end
    run(3, 2, 0, 0, 0, 0, -1, -1, 14);
    checks++;
    if (m_exec !== 32'h7E) begin errs++;
      $display("FAIL rmid_exec got %h want 7e", m_exec); end
    checks++;
    if (m_outr !== 32'h120) begin errs++;
      $display("FAIL rmid_outr got %h want 120", m_outr); end
    checks++;
    if (m_done !== 32'h200) begin errs++;
      $display("FAIL rmid_done got %h want 200", m_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_empty();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
      errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
